// File: rtl/pcie_rp_chaining_dma_driver_if.sv
// Request/completion bus between the root-port test sequencer and the request engine.
// The sequencer is the master: it issues requests and consumes read completions.
interface pcie_rp_chaining_dma_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        cpl_valid;
  logic [31:0] cpl_data;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, cpl_valid, cpl_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, cpl_valid, cpl_data
  );
endinterface

// File: rtl/pcie_rp_chaining_dma_driver.sv
// Root-port test sequencer: config write, chaining-DMA descriptor programming, optional
// target read-back, pass/fail report. Define CHAIN_DRV_TIMEOUT_EN to bound every wait.
module pcie_rp_chaining_dma_driver #(
  parameter int TEST_LEVEL     = 1,
  parameter int USE_CDMA       = 1,
  parameter int USE_TARGET     = 0,
  parameter int DESC_CNT       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_in,
  input  logic rstn,
  input  logic INTA,
  input  logic INTB,
  input  logic INTC,
  input  logic INTD,
  pcie_rp_chaining_dma_driver_if.master bus,
  output logic test_done,
  output logic test_pass,
  output logic dummy_out
);

  typedef enum logic [3:0] {
    S_SETTLE, S_CFG, S_WDMA, S_WWAIT, S_RDMA, S_RWAIT,
    S_TGT_WR, S_TGT_RD, S_CHECK, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MEMWR = 2'd0, OP_MEMRD = 2'd1, OP_CFGWR = 2'd2, OP_CFGRD = 2'd3
  } op_t;

  localparam bit       CDMA_ON   = (USE_CDMA == 1) && (TEST_LEVEL > 0);
  localparam bit       TGT_ON    = (USE_TARGET == 1);
  localparam logic [7:0] LAST_PASS = 8'(TEST_LEVEL - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_settle_cnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_pass_cnt;
  logic        r_cpl_wait;
  logic        r_error;
  logic        r_test_pass;

  logic        w_valid;
  op_t         w_op;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_accept;
  logic        w_cpl_hit;
  logic        w_cpl_bad;
  logic        w_int_err;
  logic        w_timeout;
  state_t      w_after_cfg;
  state_t      w_after_dma;

  // Descriptor-header word i of a DMA table: count, reserved, table address, last index.
  function automatic logic [31:0] dma_word(input logic [1:0] i, input logic [31:0] tbl);
    case (i)
      2'd0:    return 32'(DESC_CNT);
      2'd1:    return 32'd0;
      2'd2:    return tbl;
      default: return 32'(DESC_CNT - 1);
    endcase
  endfunction

  function automatic logic [31:0] tgt_word(input logic [1:0] i);
    return 32'hA5A5_0000 | {30'd0, i};
  endfunction

  assign w_after_cfg = CDMA_ON ? S_WDMA : (TGT_ON ? S_TGT_WR : S_CHECK);
  assign w_after_dma = TGT_ON ? S_TGT_WR : S_CHECK;
  assign w_accept    = w_valid && bus.req_ready;
  assign w_cpl_hit   = r_cpl_wait && bus.cpl_valid;
  assign w_cpl_bad   = w_cpl_hit && (bus.cpl_data != tgt_word(r_idx));
  assign w_int_err   = (r_state != S_SETTLE) && (INTB || INTC || INTD);

  // Request outputs are a pure function of registered state, so they cannot move
  // while a request waits for req_ready.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_valid = 1'b0;
    w_op    = OP_MEMWR;
    w_addr  = 32'd0;
    w_data  = 32'd0;
    case (r_state)
      S_CFG: begin
        w_valid = 1'b1;
        w_op    = OP_CFGWR;
        w_addr  = 32'h0000_0004;
        w_data  = 32'h0000_0006;
      end
      S_WDMA: begin
        w_valid = 1'b1;
        w_addr  = {28'd0, r_idx, 2'b00};
        w_data  = dma_word(r_idx, 32'h0000_1000);
      end
      S_RDMA: begin
        w_valid = 1'b1;
        w_addr  = 32'h0000_0010 | {28'd0, r_idx, 2'b00};
        w_data  = dma_word(r_idx, 32'h0000_2000);
      end
      S_TGT_WR: begin
        w_valid = 1'b1;
        w_addr  = 32'h0000_0100 | {28'd0, r_idx, 2'b00};
        w_data  = tgt_word(r_idx);
      end
      S_TGT_RD: begin
        w_valid = !r_cpl_wait;
        w_op    = OP_MEMRD;
        w_addr  = 32'h0000_0100 | {28'd0, r_idx, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SETTLE: if (r_settle_cnt == 4'd15) w_next = S_CFG;
      S_CFG:    if (w_accept) w_next = w_after_cfg;
      S_WDMA:   if (w_accept && r_idx == 2'd3) w_next = S_WWAIT;
      S_WWAIT:  if (INTA) w_next = S_RDMA;
      S_RDMA:   if (w_accept && r_idx == 2'd3) w_next = S_RWAIT;
      S_RWAIT:  if (INTA) w_next = (r_pass_cnt == LAST_PASS) ? w_after_dma : S_WDMA;
      S_TGT_WR: if (w_accept && r_idx == 2'd3) w_next = S_TGT_RD;
      S_TGT_RD: if (w_cpl_hit && r_idx == 2'd3) w_next = S_CHECK;
      S_CHECK:  w_next = S_DONE;
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_SETTLE;
    endcase
    if (w_timeout) w_next = S_DONE;
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rstn) r_state <= S_SETTLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      r_settle_cnt <= 4'd0;
      r_idx        <= 2'd0;
      r_pass_cnt   <= 8'd0;
      r_cpl_wait   <= 1'b0;
      r_error      <= 1'b0;
      r_test_pass  <= 1'b0;
    end else begin
      if (r_state == S_SETTLE) r_settle_cnt <= r_settle_cnt + 4'd1;

      // The beat index restarts on every state change; reads advance on completion.
      if (w_next != r_state)                  r_idx <= 2'd0;
      else if (w_accept && !w_op[0])          r_idx <= r_idx + 2'd1;
      else if (w_cpl_hit)                     r_idx <= r_idx + 2'd1;

      if (w_next != r_state)                  r_cpl_wait <= 1'b0;
      else if (w_accept && w_op == OP_MEMRD)  r_cpl_wait <= 1'b1;
      else if (w_cpl_hit)                     r_cpl_wait <= 1'b0;

      if (r_state == S_RWAIT && w_next != S_RWAIT) r_pass_cnt <= r_pass_cnt + 8'd1;

      if (w_int_err || w_cpl_bad || w_timeout) r_error <= 1'b1;

      if (r_state == S_CHECK) r_test_pass <= !(r_error || w_int_err);
    end
  end

`ifdef CHAIN_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_waiting;
  logic          w_wait_hit;

  assign w_waiting  = (r_state == S_WWAIT) || (r_state == S_RWAIT) || r_cpl_wait;
  assign w_wait_hit = (((r_state == S_WWAIT) || (r_state == S_RWAIT)) && INTA) || w_cpl_hit;
  assign w_timeout  = w_waiting && !w_wait_hit && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (!rstn)                                  r_tmo_cnt <= '0;
    else if (w_next != r_state || !w_waiting)   r_tmo_cnt <= '0;
    else                                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  assign bus.req_valid = w_valid;
  assign bus.req_op    = w_op;
  assign bus.req_addr  = w_addr;
  assign bus.req_data  = w_data;
  assign test_done     = (r_state == S_DONE);
  assign test_pass     = (r_state == S_DONE) && r_test_pass;
  assign dummy_out     = 1'b0;

endmodule

// File: tb/tb_pcie_rp_chaining_dma_driver.sv
// Directed bench for pcie_rp_chaining_dma_driver: a target-enabled instance exercised by
// per-scenario tasks, plus a default-parameter instance for the plain DMA sequence.
module tb_pcie_rp_chaining_dma_driver;

  logic clk_in = 1'b0;
  logic rstn, inta, intb, intc, intd;
  logic test_done, test_pass, dummy_out;

  logic d_rstn, d_inta, d_intb, d_intc, d_intd;
  logic d_done, d_pass, d_dummy;

  pcie_rp_chaining_dma_driver_if bus ();
  pcie_rp_chaining_dma_driver_if d_bus ();

  pcie_rp_chaining_dma_driver #(
    .TEST_LEVEL(1), .USE_CDMA(1), .USE_TARGET(1), .DESC_CNT(4), .TIMEOUT_CYCLES(64)
  ) u_dut (
    .clk_in(clk_in), .rstn(rstn),
    .INTA(inta), .INTB(intb), .INTC(intc), .INTD(intd),
    .bus(bus.master),
    .test_done(test_done), .test_pass(test_pass), .dummy_out(dummy_out)
  );

  pcie_rp_chaining_dma_driver u_dut_dflt (
    .clk_in(clk_in), .rstn(d_rstn),
    .INTA(d_inta), .INTB(d_intb), .INTC(d_intc), .INTD(d_intd),
    .bus(d_bus.master),
    .test_done(d_done), .test_pass(d_pass), .dummy_out(d_dummy)
  );

  always #5 clk_in = ~clk_in;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0]  log_op   [64];
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [31:0] mem [logic [31:0]];
  int n_xfer, cyc, wr0c_cyc, done_cyc;

  task automatic do_reset();
    rstn = 1'b0;
    inta = 1'b1; intb = 1'b0; intc = 1'b0; intd = 1'b0;
    bus.req_ready = 1'b1; bus.cpl_valid = 1'b0; bus.cpl_data = 32'd0;
    repeat (3) @(negedge clk_in);
    rstn = 1'b1;
  endtask

  // Slave responder: accepts requests, echoes target writes back on reads two cycles
  // after acceptance, optionally stalls one request, corrupts one completion, or
  // pulses INTB. Stops on test_done, after stop_xfers transfers, or at max_cycles.
  task automatic run_seq(input int max_cycles, input int stop_xfers, input int stall_at,
                         input int corrupt_at, input int intb_at);
    bit          rd_pending = 1'b0;
    int          rd_wait = 0, rd_n = 0, stall_cnt = 0;
    bit          intb_done = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic [1:0]  s_op = 2'd0;
    logic [31:0] s_addr = 32'd0, s_data = 32'd0;
    n_xfer = 0; cyc = 0; wr0c_cyc = -1; done_cyc = -1;
    mem.delete();
    while (cyc < max_cycles) begin
      @(negedge clk_in);
      cyc++;
      bus.cpl_valid = 1'b0;
      bus.cpl_data  = 32'd0;
      intb = 1'b0;
      if (test_done) begin
        done_cyc = cyc;
        break;
      end
      if (rd_pending) begin
        compared++;
        if (bus.req_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL outstanding: req_valid=%b during read wait, required 0", bus.req_valid);
        end
        rd_wait--;
        if (rd_wait == 0) begin
          bus.cpl_valid = 1'b1;
          bus.cpl_data  = (rd_n == corrupt_at) ? 32'd0 : mem[rd_addr];
          rd_n++;
          rd_pending = 1'b0;
        end
      end
      if (n_xfer == intb_at && !intb_done) begin
        intb = 1'b1;
        intb_done = 1'b1;
      end
      if (bus.req_valid && n_xfer == stall_at && stall_cnt < 5) begin
        if (stall_cnt == 0) begin
          s_op = bus.req_op; s_addr = bus.req_addr; s_data = bus.req_data;
        end else begin
          compared++;
          if ({bus.req_valid, bus.req_op, bus.req_addr, bus.req_data} !== {1'b1, s_op, s_addr, s_data}) begin
            mismatched++;
            $display("FAIL stall_stable: got v=%b op=%0d a=%h d=%h, required v=1 op=%0d a=%h d=%h",
                     bus.req_valid, bus.req_op, bus.req_addr, bus.req_data, s_op, s_addr, s_data);
          end
        end
        bus.req_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.req_ready = 1'b1;
      end
      if (bus.req_valid && bus.req_ready) begin
        log_op[n_xfer] = bus.req_op; log_addr[n_xfer] = bus.req_addr; log_data[n_xfer] = bus.req_data;
        if (bus.req_op == 2'd0) mem[bus.req_addr] = bus.req_data;
        if (bus.req_op == 2'd0 && bus.req_addr == 32'h0C) wr0c_cyc = cyc;
        if (bus.req_op == 2'd1) begin
          rd_pending = 1'b1; rd_wait = 2; rd_addr = bus.req_addr;
        end
        n_xfer++;
        if (n_xfer == stop_xfers) break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    inta = 1'b1; intb = 1'b0; intc = 1'b0; intd = 1'b0;
    bus.req_ready = 1'b1; bus.cpl_valid = 1'b0; bus.cpl_data = 32'd0;
    repeat (2) @(negedge clk_in);
    compared++;
    if ({bus.req_valid, bus.req_op, bus.req_addr, bus.req_data, test_done, test_pass, dummy_out} !== 70'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: v=%b op=%0d a=%h d=%h done=%b pass=%b dummy=%b, required all 0",
               bus.req_valid, bus.req_op, bus.req_addr, bus.req_data, test_done, test_pass, dummy_out);
    end
  endtask

  task automatic test_settle();
    int c = 0;
    do_reset();
    bus.req_ready = 1'b0;
    while (c < 40) begin
      @(negedge clk_in);
      c++;
      if (bus.req_valid) break;
    end
    compared++;
    if (c != 16) begin
      mismatched++;
      $display("FAIL settle_len: first req_valid after %0d cycles, required 16", c);
    end
    compared++;
    if ({bus.req_op, bus.req_addr, bus.req_data} !== {2'd2, 32'h4, 32'h6}) begin
      mismatched++;
      $display("FAIL cfg_req: op=%0d a=%h d=%h, required op=2 a=00000004 d=00000006",
               bus.req_op, bus.req_addr, bus.req_data);
    end
  endtask

  task automatic test_target_pass();
    logic [1:0]  e_op [17];
    logic [31:0] e_a [17], e_d [17];
    e_op[0] = 2'd2; e_a[0] = 32'h4; e_d[0] = 32'h6;
    for (int i = 0; i < 4; i++) begin
      e_op[1+i]  = 2'd0; e_a[1+i]  = 32'(4 * i);
      e_op[5+i]  = 2'd0; e_a[5+i]  = 32'(32'h10 + 4 * i);
      e_op[9+i]  = 2'd0; e_a[9+i]  = 32'(32'h100 + 4 * i); e_d[9+i] = 32'(32'hA5A5_0000 + i);
      e_op[13+i] = 2'd1; e_a[13+i] = 32'(32'h100 + 4 * i); e_d[13+i] = 32'd0;
    end
    e_d[1] = 32'd4; e_d[2] = 32'd0; e_d[3] = 32'h1000; e_d[4] = 32'd3;
    e_d[5] = 32'd4; e_d[6] = 32'd0; e_d[7] = 32'h2000; e_d[8] = 32'd3;
    do_reset();
    run_seq(400, -1, 3, -1, -1);
    compared++;
    if (n_xfer != 17) begin
      mismatched++;
      $display("FAIL tgt_xfer_count: %0d transfers, required 17", n_xfer);
    end
    for (int i = 0; i < 17 && i < n_xfer; i++) begin
      compared++;
      if (log_op[i] !== e_op[i] || log_addr[i] !== e_a[i] || (e_op[i] != 2'd1 && log_data[i] !== e_d[i])) begin
        mismatched++;
        $display("FAIL xfer%0d: op=%0d a=%h d=%h, required op=%0d a=%h d=%h",
                 i, log_op[i], log_addr[i], log_data[i], e_op[i], e_a[i], e_d[i]);
      end
    end
    compared++;
    if ({test_done, test_pass, dummy_out} !== 3'b110) begin
      mismatched++;
      $display("FAIL tgt_pass: done=%b pass=%b dummy=%b, required 1 1 0", test_done, test_pass, dummy_out);
    end
    repeat (5) @(negedge clk_in);
    compared++;
    if ({bus.req_valid, test_done, test_pass} !== 3'b011) begin
      mismatched++;
      $display("FAIL done_hold: valid=%b done=%b pass=%b, required 0 1 1", bus.req_valid, test_done, test_pass);
    end
  endtask

  task automatic test_target_corrupt();
    do_reset();
    run_seq(400, -1, -1, 2, -1);
    compared++;
    if ({n_xfer == 17, test_done, test_pass} !== 3'b110) begin
      mismatched++;
      $display("FAIL tgt_corrupt: xfers=%0d done=%b pass=%b, required 17 1 0", n_xfer, test_done, test_pass);
    end
  endtask

  task automatic test_intb_pulse();
    do_reset();
    run_seq(400, -1, -1, -1, 2);
    compared++;
    if ({n_xfer == 17, test_done, test_pass} !== 3'b110) begin
      mismatched++;
      $display("FAIL intb_pulse: xfers=%0d done=%b pass=%b, required 17 1 0", n_xfer, test_done, test_pass);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    inta = 1'b0;
    run_seq(300, -1, -1, -1, -1);
    compared++;
    if (n_xfer != 5 || wr0c_cyc < 0) begin
      mismatched++;
      $display("FAIL tmo_xfers: %0d transfers (0x0C seen at %0d), required 5", n_xfer, wr0c_cyc);
    end
`ifdef CHAIN_DRV_TIMEOUT_EN
    compared++;
    if (done_cyc < wr0c_cyc + 60 || done_cyc > wr0c_cyc + 70 || test_pass !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout: done %0d cycles after 0x0C write, pass=%b, required ~64 and 0",
               done_cyc - wr0c_cyc, test_pass);
    end
`else
    compared++;
    if (test_done !== 1'b0) begin
      mismatched++;
      $display("FAIL no_timeout: test_done=%b while INTA=0, required 0", test_done);
    end
`endif
    inta = 1'b1;
  endtask

  task automatic test_reset_mid_rdma();
    do_reset();
    run_seq(400, 6, -1, -1, -1);
    rstn = 1'b0;
    @(negedge clk_in);
    compared++;
    if ({bus.req_valid, bus.req_op, bus.req_addr, bus.req_data, test_done, test_pass, dummy_out} !== 70'd0) begin
      mismatched++;
      $display("FAIL midreset_outputs: v=%b op=%0d a=%h d=%h done=%b pass=%b, required all 0",
               bus.req_valid, bus.req_op, bus.req_addr, bus.req_data, test_done, test_pass);
    end
    rstn = 1'b1;
    run_seq(400, -1, -1, -1, -1);
    compared++;
    if ({n_xfer == 17, log_op[0], log_addr[0], test_done, test_pass} !== {1'b1, 2'd2, 32'h4, 2'b11}) begin
      mismatched++;
      $display("FAIL midreset_restart: xfers=%0d first op=%0d a=%h done=%b pass=%b, required 17 2 00000004 1 1",
               n_xfer, log_op[0], log_addr[0], test_done, test_pass);
    end
  endtask

  task automatic test_default_params();
    int n = 0;
    logic [31:0] last_a = 32'd0, last_d = 32'd0;
    d_rstn = 1'b0; d_inta = 1'b1; d_intb = 1'b0; d_intc = 1'b0; d_intd = 1'b0;
    d_bus.req_ready = 1'b1; d_bus.cpl_valid = 1'b0; d_bus.cpl_data = 32'd0;
    repeat (3) @(negedge clk_in);
    d_rstn = 1'b1;
    for (int c = 0; c < 200 && !d_done; c++) begin
      @(negedge clk_in);
      if (d_bus.req_valid) begin
        n++;
        last_a = d_bus.req_addr;
        last_d = d_bus.req_data;
      end
    end
    compared++;
    if (n != 9 || last_a !== 32'h1C || last_d !== 32'd3) begin
      mismatched++;
      $display("FAIL dflt_seq: %0d transfers, last a=%h d=%h, required 9 0000001c 00000003", n, last_a, last_d);
    end
    compared++;
    if ({d_done, d_pass, d_dummy} !== 3'b110) begin
      mismatched++;
      $display("FAIL dflt_pass: done=%b pass=%b dummy=%b, required 1 1 0", d_done, d_pass, d_dummy);
    end
  endtask

  initial begin
    d_rstn = 1'b0; d_inta = 1'b1; d_intb = 1'b0; d_intc = 1'b0; d_intd = 1'b0;
    d_bus.req_ready = 1'b1; d_bus.cpl_valid = 1'b0; d_bus.cpl_data = 32'd0;
    test_reset();
    test_settle();
    test_target_pass();
    test_target_corrupt();
    test_intb_pulse();
    test_timeout();
    test_reset_mid_rdma();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
